// File: rtl/windowed_regfile.sv
// Register-window file: 2^AW visible registers per window over a circular physical array,
// with call/return window moves and a spill/fill engine streaming the oldest window to a memory stack.
module windowed_regfile #(
    parameter int DW   = 16,
    parameter int AW   = 2,
    parameter int STEP = 2,
    parameter int NWIN = 4,
    parameter int SPW  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [AW-1:0]           rd_addr1_i,
    input  logic [AW-1:0]           rd_addr2_i,
    output logic [DW-1:0]           rd_data1_o,
    output logic [DW-1:0]           rd_data2_o,
    input  logic                    wr_en_i,
    input  logic [AW-1:0]           wr_addr_i,
    input  logic [DW-1:0]           wr_data_i,
    input  logic                    call_i,
    input  logic                    ret_i,
    output logic                    cmd_ready_o,
    output logic                    busy_o,
    output logic [$clog2(NWIN)-1:0] cwp_o,
    output logic                    err_o,
    output logic                    spill_valid_o,
    output logic [DW-1:0]           spill_data_o,
    input  logic                    spill_ready_i,
    output logic                    fill_req_o,
    input  logic                    fill_valid_i,
    input  logic [DW-1:0]           fill_data_i
);

    localparam int CW   = $clog2(NWIN);
    localparam int PHYS = NWIN * STEP;
    localparam int PW   = (PHYS > 1) ? $clog2(PHYS) : 1;
    localparam int KW   = (STEP > 1) ? $clog2(STEP) : 1;
    localparam logic [CW-1:0]  RES_MAX = CW'(NWIN - 2);
    localparam logic [CW-1:0]  WIN_ONE = CW'(1);
    localparam logic [SPW-1:0] SPL_MAX = {SPW{1'b1}};
    localparam logic [KW-1:0]  K_LAST  = KW'(STEP - 1);
    localparam logic [AW-1:0]  TOP_IDX = AW'(STEP - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SPILL = 2'd1,
        ST_FILL  = 2'd2
    } state_t;

    function automatic logic [PW-1:0] phys_idx(input logic [CW-1:0] w, input logic [AW-1:0] i);
        int t;
        t = (int'(w) * STEP + int'(i)) % PHYS;
        return PW'(t);
    endfunction

    function automatic logic [CW-1:0] win_inc(input logic [CW-1:0] w);
        return (int'(w) == NWIN - 1) ? {CW{1'b0}} : CW'(int'(w) + 1);
    endfunction

    function automatic logic [CW-1:0] win_sub(input logic [CW-1:0] a, input logic [CW-1:0] b);
        int t;
        t = int'(a) - int'(b);
        return (t < 32'sd0) ? CW'(t + NWIN) : CW'(t);
    endfunction

    function automatic logic [PW-1:0] p_inc(input logic [PW-1:0] p);
        return (int'(p) == PHYS - 1) ? {PW{1'b0}} : PW'(int'(p) + 1);
    endfunction

    function automatic logic [PW-1:0] p_dec(input logic [PW-1:0] p);
        return (p == {PW{1'b0}}) ? PW'(PHYS - 1) : PW'(int'(p) - 1);
    endfunction

    state_t         state_q, state_d;
    logic [CW-1:0]  cwp_q, cwp_d;
    logic [CW-1:0]  res_q, res_d;
    logic [SPW-1:0] spl_q, spl_d;
    logic [KW-1:0]  k_q, k_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [DW-1:0]  sdata_q, sdata_d;
    logic           err_q, err_d;
    logic [DW-1:0]  regs_q [PHYS];
    logic [DW-1:0]  rd1_q, rd2_q;

    logic           we_s;
    logic [PW-1:0]  waddr_s;
    logic [DW-1:0]  wdata_s;
    logic [PW-1:0]  rphys1_s, rphys2_s, spill_start_s, fill_start_s;

    // Next-state logic for window control, spill/fill sequencing and the physical write port
    always_comb begin
        state_d       = state_q;
        cwp_d         = cwp_q;
        res_d         = res_q;
        spl_d         = spl_q;
        k_d           = k_q;
        ptr_d         = ptr_q;
        sdata_d       = sdata_q;
        err_d         = 1'b0;
        we_s          = 1'b0;
        waddr_s       = phys_idx(cwp_q, wr_addr_i);
        wdata_s       = wr_data_i;
        rphys1_s      = phys_idx(cwp_q, rd_addr1_i);
        rphys2_s      = phys_idx(cwp_q, rd_addr2_i);
        spill_start_s = phys_idx(win_sub(cwp_q, res_q), {AW{1'b0}});
        fill_start_s  = phys_idx(win_sub(cwp_q, WIN_ONE), TOP_IDX);
        case (state_q)
            ST_IDLE: begin
                we_s = wr_en_i;
                if (call_i && ret_i) begin
                    err_d = 1'b1;
                end else if (call_i) begin
                    if (res_q < RES_MAX) begin
                        cwp_d = win_inc(cwp_q);
                        res_d = res_q + WIN_ONE;
                    end else if (spl_q != SPL_MAX) begin
                        state_d = ST_SPILL;
                        k_d     = {KW{1'b0}};
                        ptr_d   = spill_start_s;
                        // A same-cycle write into the first spilled register must be seen by beat 0
                        sdata_d = (we_s && (waddr_s == spill_start_s)) ? wdata_s
                                                                       : regs_q[spill_start_s];
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (ret_i) begin
                    if (res_q != {CW{1'b0}}) begin
                        cwp_d = win_sub(cwp_q, WIN_ONE);
                        res_d = res_q - WIN_ONE;
                    end else if (spl_q != {SPW{1'b0}}) begin
                        state_d = ST_FILL;
                        k_d     = {KW{1'b0}};
                        ptr_d   = fill_start_s;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SPILL: begin
                if (spill_ready_i) begin
                    if (k_q == K_LAST) begin
                        state_d = ST_IDLE;
                        cwp_d   = win_inc(cwp_q);
                        spl_d   = spl_q + {{(SPW-1){1'b0}}, 1'b1};
                    end else begin
                        k_d     = k_q + {{(KW-1){1'b0}}, 1'b1};
                        ptr_d   = p_inc(ptr_q);
                        sdata_d = regs_q[p_inc(ptr_q)];
                    end
                end else begin
                    state_d = ST_SPILL;
                end
            end
            ST_FILL: begin
                if (fill_valid_i) begin
                    we_s    = 1'b1;
                    waddr_s = ptr_q;
                    wdata_s = fill_data_i;
                    if (k_q == K_LAST) begin
                        state_d = ST_IDLE;
                        cwp_d   = win_sub(cwp_q, WIN_ONE);
                        spl_d   = spl_q - {{(SPW-1){1'b0}}, 1'b1};
                    end else begin
                        k_d   = k_q + {{(KW-1){1'b0}}, 1'b1};
                        ptr_d = p_dec(ptr_q);
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cwp_q   <= {CW{1'b0}};
            res_q   <= {CW{1'b0}};
            spl_q   <= {SPW{1'b0}};
            k_q     <= {KW{1'b0}};
            ptr_q   <= {PW{1'b0}};
            sdata_q <= {DW{1'b0}};
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cwp_q   <= cwp_d;
            res_q   <= res_d;
            spl_q   <= spl_d;
            k_q     <= k_d;
            ptr_q   <= ptr_d;
            sdata_q <= sdata_d;
            err_q   <= err_d;
        end
    end

    // Physical register array, single write port shared by user writes and fill beats
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PHYS; i++) begin
                regs_q[i] <= {DW{1'b0}};
            end
        end else if (we_s) begin
            regs_q[waddr_s] <= wdata_s;
        end
    end

    // Registered read ports with write bypass; held while the engine is busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd1_q <= {DW{1'b0}};
            rd2_q <= {DW{1'b0}};
        end else if (state_q == ST_IDLE) begin
            rd1_q <= (we_s && (waddr_s == rphys1_s)) ? wdata_s : regs_q[rphys1_s];
            rd2_q <= (we_s && (waddr_s == rphys2_s)) ? wdata_s : regs_q[rphys2_s];
        end
    end

    assign rd_data1_o    = rd1_q;
    assign rd_data2_o    = rd2_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign cmd_ready_o   = (state_q == ST_IDLE);
    assign cwp_o         = cwp_q;
    assign err_o         = err_q;
    assign spill_valid_o = (state_q == ST_SPILL);
    assign spill_data_o  = sdata_q;
    assign fill_req_o    = (state_q == ST_FILL);

endmodule

// File: tb/tb_windowed_regfile.sv
// Scoreboard bench for windowed_regfile: stimulus queues expected responses, a negedge monitor
// pops and compares them against reads, status, spill beats and error pulses.
module tb_windowed_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  rd_addr1 = 2'd0, rd_addr2 = 2'd0, wr_addr = 2'd0;
    logic [15:0] rd_data1, rd_data2, wr_data = 16'h0, spill_data, fill_data = 16'h0;
    logic        wr_en = 1'b0, call = 1'b0, ret = 1'b0;
    logic        cmd_ready, busy, err, spill_valid, fill_req;
    logic        spill_ready = 1'b0, fill_valid = 1'b0;
    logic [1:0]  cwp;

    always #5 clk = ~clk;

    windowed_regfile #(.DW(16), .AW(2), .STEP(2), .NWIN(4), .SPW(8)) dut (
        .clk(clk), .rst(rst),
        .rd_addr1_i(rd_addr1), .rd_addr2_i(rd_addr2),
        .rd_data1_o(rd_data1), .rd_data2_o(rd_data2),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .call_i(call), .ret_i(ret),
        .cmd_ready_o(cmd_ready), .busy_o(busy), .cwp_o(cwp), .err_o(err),
        .spill_valid_o(spill_valid), .spill_data_o(spill_data), .spill_ready_i(spill_ready),
        .fill_req_o(fill_req), .fill_valid_i(fill_valid), .fill_data_i(fill_data)
    );

    typedef struct packed {
        logic [15:0] d1;
        logic [15:0] d2;
        logic [1:0]  cwp;
    } rd_exp_t;

    typedef struct packed {
        logic [1:0]  cwp;
        logic        busy;
        logic        sv;
        logic        fr;
        logic        chk_sd;
        logic [15:0] sd;
    } st_exp_t;

    rd_exp_t     rd_q[$];
    st_exp_t     st_q[$];
    logic [15:0] sp_q[$];
    rd_exp_t     mon_r;
    st_exp_t     mon_s;
    logic        rd_tag = 1'b0, st_tag = 1'b0, err_tag = 1'b0;
    logic        rd_due = 1'b0, err_due = 1'b0;
    int          nvec = 0;
    int          nmis = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs are stable at negedge; inputs change 1 time unit after posedge
    always @(negedge clk) begin
        if (rd_due) begin
            if (rd_q.size() == 0) begin
                nvec++; nmis++;
                $display("FAIL rd_scoreboard: got read with no expectation queued");
            end else begin
                mon_r = rd_q.pop_front();
                chk("rd_data1", 32'(rd_data1), 32'(mon_r.d1));
                chk("rd_data2", 32'(rd_data2), 32'(mon_r.d2));
                chk("rd_cwp",   32'(cwp),      32'(mon_r.cwp));
            end
        end
        rd_due = rd_tag;
        if (st_tag && st_q.size() != 0) begin
            mon_s = st_q.pop_front();
            chk("cwp",         32'(cwp),         32'(mon_s.cwp));
            chk("busy",        32'(busy),        32'(mon_s.busy));
            chk("cmd_ready",   32'(cmd_ready),   32'(!mon_s.busy));
            chk("spill_valid", 32'(spill_valid), 32'(mon_s.sv));
            chk("fill_req",    32'(fill_req),    32'(mon_s.fr));
            if (mon_s.chk_sd) chk("spill_data", 32'(spill_data), 32'(mon_s.sd));
        end
        if (spill_valid && spill_ready) begin
            if (sp_q.size() == 0) begin
                nvec++; nmis++;
                $display("FAIL spill_beat: got unexpected beat 0x%0h", spill_data);
            end else begin
                chk("spill_beat", 32'(spill_data), 32'(sp_q.pop_front()));
            end
        end
        if (err_due || err) chk("err", 32'(err), 32'(err_due));
        err_due = err_tag;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        call = 1'b0; ret = 1'b0; wr_en = 1'b0; fill_valid = 1'b0;
        rd_tag = 1'b0; st_tag = 1'b0; err_tag = 1'b0;
    endtask

    task automatic expect_st(input logic [1:0] c, input logic b, input logic sv, input logic fr,
                             input logic csd, input logic [15:0] sd);
        st_q.push_back({c, b, sv, fr, csd, sd});
        st_tag = 1'b1;
    endtask

    task automatic expect_rd(input logic [1:0] a1, input logic [1:0] a2,
                             input logic [15:0] d1, input logic [15:0] d2, input logic [1:0] c);
        rd_addr1 = a1;
        rd_addr2 = a2;
        rd_q.push_back({d1, d2, c});
        rd_tag = 1'b1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
    endtask

    initial begin
        tick(); tick();
        expect_st(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000); tick();
        rst = 1'b0;
        // Underflow right after reset, then simultaneous call/ret
        ret = 1'b1; err_tag = 1'b1; tick();
        expect_st(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0); tick();
        call = 1'b1; ret = 1'b1; err_tag = 1'b1; tick();
        expect_st(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0); tick();
        // Bypass, then window overlap
        wr(2'd3, 16'h1234); expect_rd(2'd3, 2'd0, 16'h1234, 16'h0000, 2'd0); tick();
        wr(2'd2, 16'hAAAA); tick();
        call = 1'b1; tick();
        expect_rd(2'd0, 2'd1, 16'hAAAA, 16'h1234, 2'd1); tick();
        ret = 1'b1; tick();
        wr(2'd0, 16'h0A0A); tick();
        wr(2'd1, 16'h0B0B); tick();
        // Spill at zero-wait memory; write during busy must be dropped
        spill_ready = 1'b1;
        call = 1'b1; tick();
        call = 1'b1; tick();
        expect_st(2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        call = 1'b1; sp_q.push_back(16'h0A0A); sp_q.push_back(16'h0B0B); tick();
        expect_st(2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0A0A); wr(2'd0, 16'hDEAD); tick();
        expect_st(2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0B0B); tick();
        expect_st(2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0); wr(2'd2, 16'h5555); tick();
        wr(2'd3, 16'h6666); tick();
        expect_rd(2'd2, 2'd3, 16'h5555, 16'h6666, 2'd3); tick();
        ret = 1'b1; tick();
        expect_rd(2'd0, 2'd2, 16'h0000, 16'h0000, 2'd2); tick();
        ret = 1'b1; tick();
        // Fill of window 0 in stack-pop order
        ret = 1'b1; tick();
        expect_st(2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0); fill_valid = 1'b1; fill_data = 16'h0B0B; tick();
        expect_st(2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0); fill_valid = 1'b1; fill_data = 16'h0A0A; tick();
        expect_st(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        expect_rd(2'd0, 2'd1, 16'h0A0A, 16'h0B0B, 2'd0); tick();
        ret = 1'b1; err_tag = 1'b1; tick();
        expect_st(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0); tick();
        // Backpressure holds the beat, then reset aborts the spill
        spill_ready = 1'b0;
        call = 1'b1; tick();
        call = 1'b1; tick();
        call = 1'b1; sp_q.push_back(16'h0A0A); tick();
        for (int i = 0; i < 5; i++) begin
            expect_st(2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0A0A); tick();
        end
        spill_ready = 1'b1; expect_st(2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0A0A); tick();
        rst = 1'b1; expect_st(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000); tick();
        rst = 1'b0; spill_ready = 1'b0;
        expect_rd(2'd0, 2'd1, 16'h0000, 16'h0000, 2'd0); tick();
        tick(); tick();
        chk("rd_queue_drained",    32'(rd_q.size()), 32'd0);
        chk("spill_queue_drained", 32'(sp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
